// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine credit controller.
// The optional auto-change behaviour is selected with the VEND_AUTO_CHANGE_EN macro.
package vend_pkg;

  localparam int WIDTH_DEFAULT = 5;

  localparam int COIN_1  = 1;
  localparam int COIN_5  = 5;
  localparam int COIN_10 = 10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    EXEC_ADD = 3'd1,
    EXEC_SUB = 3'd2,
    EXEC_REF = 3'd3,
    RESP     = 3'd4
  } vend_state_t;

  function automatic logic is_exec(vend_state_t s);
    return (s == EXEC_ADD) || (s == EXEC_SUB) || (s == EXEC_REF);
  endfunction

endpackage

// File: rtl/vend_credit_ctrl_addsub.sv
// Shared adder/subtractor: one carry chain computes a+b or a-b.
// carry_borrow is carry-out when adding and borrow (a < b) when subtracting.
module vend_credit_ctrl_addsub #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] result,
  output logic             carry_borrow
);

  logic [WIDTH:0] full_sum;
  logic [WIDTH-1:0] b_eff;

  // Subtraction is a + ~b + 1; the inverted carry-out is the borrow.
  assign b_eff = b ^ {WIDTH{sub}};
  assign full_sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  assign result = full_sum[WIDTH-1:0];
  assign carry_borrow = sub ? ~full_sum[WIDTH] : full_sum[WIDTH];

endmodule

// File: rtl/vend_credit_ctrl.sv
// Credit controller: arbitrates coin/buy/refund, sequences one shared add/sub unit.
// Build option VEND_AUTO_CHANGE_EN returns remaining credit after each successful purchase.
//
// Handshake: every request is a level held by the requester; the controller samples
// it only in IDLE and answers with a one-cycle pulse in RESP. The requester drops
// its request on the clock edge that ends the pulse cycle; a request still high in
// the following IDLE cycle is a new request.
module vend_credit_ctrl
  import vend_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             coin_req,
  input  logic [WIDTH-1:0] coin_val,
  input  logic             buy_req,
  input  logic [WIDTH-1:0] price,
  input  logic             refund_req,
  output logic             coin_ack,
  output logic             coin_reject,
  output logic             dispense,
  output logic             insufficient,
  output logic             change_valid,
  output logic [WIDTH-1:0] change_val,
  output logic [WIDTH-1:0] credit,
  output logic             busy
);

  vend_state_t      state;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] au_result;
  logic             au_cb;
  logic             au_sub;

  assign au_sub = (state == EXEC_SUB);

  vend_credit_ctrl_addsub #(
    .WIDTH(WIDTH)
  ) u_addsub (
    .a           (credit),
    .b           (op_b),
    .sub         (au_sub),
    .result      (au_result),
    .carry_borrow(au_cb)
  );

`ifdef VEND_AUTO_CHANGE_EN
  // Remembers a successful purchase across EXEC_REF so dispense lands in RESP.
  logic dispense_pend;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      op_b         <= '0;
      credit       <= '0;
      change_val   <= '0;
      coin_ack     <= 1'b0;
      coin_reject  <= 1'b0;
      dispense     <= 1'b0;
      insufficient <= 1'b0;
      change_valid <= 1'b0;
      busy         <= 1'b0;
`ifdef VEND_AUTO_CHANGE_EN
      dispense_pend <= 1'b0;
`endif
    end else begin
      // Pulses default low; EXEC states set them so they are high only in RESP.
      coin_ack     <= 1'b0;
      coin_reject  <= 1'b0;
      dispense     <= 1'b0;
      insufficient <= 1'b0;
      change_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (refund_req) begin
            state <= EXEC_REF;
            busy  <= 1'b1;
          end else if (buy_req) begin
            op_b  <= price;
            state <= EXEC_SUB;
            busy  <= 1'b1;
          end else if (coin_req) begin
            op_b  <= coin_val;
            state <= EXEC_ADD;
            busy  <= 1'b1;
          end
        end

        EXEC_ADD: begin
          if (!au_cb) begin
            credit   <= au_result;
            coin_ack <= 1'b1;
          end else begin
            coin_reject <= 1'b1;
          end
          state <= RESP;
        end

        EXEC_SUB: begin
          if (!au_cb) begin
            credit <= au_result;
`ifdef VEND_AUTO_CHANGE_EN
            dispense_pend <= 1'b1;
            state         <= EXEC_REF;
`else
            dispense <= 1'b1;
            state    <= RESP;
`endif
          end else begin
            insufficient <= 1'b1;
            state        <= RESP;
          end
        end

        EXEC_REF: begin
          change_val   <= credit;
          change_valid <= 1'b1;
          credit       <= '0;
`ifdef VEND_AUTO_CHANGE_EN
          dispense      <= dispense_pend;
          dispense_pend <= 1'b0;
`endif
          state <= RESP;
        end

        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Self-checking bench for vend_credit_ctrl: directed table, corner sequences, random vs model.
// Expectations follow VEND_AUTO_CHANGE_EN when the bench is built with that macro.
module tb_vend_credit_ctrl;
  import vend_pkg::*;

  localparam int W = WIDTH_DEFAULT;
  localparam logic [1:0] K_COIN = 2'd0;
  localparam logic [1:0] K_BUY  = 2'd1;
  localparam logic [1:0] K_REF  = 2'd2;

  typedef struct {
    logic [1:0]   kind;
    logic [W-1:0] val;
    logic         ack;
    logic         rej;
    logic         disp;
    logic         insuf;
    logic         chg;
    logic [W-1:0] chg_val;
    logic [W-1:0] cr;
    int           lat;
  } txn_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         coin_req = 1'b0;
  logic [W-1:0] coin_val = '0;
  logic         buy_req = 1'b0;
  logic [W-1:0] price = '0;
  logic         refund_req = 1'b0;
  logic         coin_ack, coin_reject, dispense, insufficient, change_valid, busy;
  logic [W-1:0] change_val, credit;

  int n_checks = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  vend_credit_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .coin_req(coin_req), .coin_val(coin_val),
    .buy_req(buy_req), .price(price),
    .refund_req(refund_req),
    .coin_ack(coin_ack), .coin_reject(coin_reject),
    .dispense(dispense), .insufficient(insufficient),
    .change_valid(change_valid), .change_val(change_val),
    .credit(credit), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic any_pulse();
    return coin_ack | coin_reject | dispense | insufficient | change_valid;
  endfunction

  // Waits on negedges for a response pulse; n counts cycles from the request cycle.
  task automatic wait_pulse(input string tag, output int n, output bit got);
    n = 0;
    got = 1'b0;
    while (!got && n < 12) begin
      @(negedge clk);
      if (any_pulse()) got = 1'b1;
      else begin
        if (n == 1) chk({tag, " busy_exec"}, busy, 1);
        n++;
      end
    end
    if (!got) chk({tag, " timeout"}, 0, 1);
  endtask

  task automatic drop_all();
    coin_req = 1'b0;
    buy_req = 1'b0;
    refund_req = 1'b0;
  endtask

  // driver: one request, compare the response, release on the edge ending the pulse
  task automatic run_txn(input string tag, input txn_t t);
    int n;
    bit got;
    exp_q.push_back(t.cr);
    case (t.kind)
      K_COIN: begin coin_req = 1'b1; coin_val = t.val; end
      K_BUY:  begin buy_req = 1'b1; price = t.val; end
      default: refund_req = 1'b1;
    endcase
    wait_pulse(tag, n, got);
    if (got) begin
      chk({tag, " latency"}, n, t.lat);
      chk({tag, " coin_ack"}, coin_ack, t.ack);
      chk({tag, " coin_reject"}, coin_reject, t.rej);
      chk({tag, " dispense"}, dispense, t.disp);
      chk({tag, " insufficient"}, insufficient, t.insuf);
      chk({tag, " change_valid"}, change_valid, t.chg);
      if (t.chg) chk({tag, " change_val"}, change_val, t.chg_val);
      chk({tag, " credit"}, credit, exp_q.pop_front());
      chk({tag, " busy_resp"}, busy, 1);
    end else begin
      void'(exp_q.pop_front());
    end
    @(posedge clk);
    #1 drop_all();
  endtask

  // Reference model straight from the credit rules, in plain integers.
  function automatic txn_t model(input logic [1:0] kind, input int val, inout int cr);
    txn_t t;
    t = '{kind: kind, val: val[W-1:0], ack: 0, rej: 0, disp: 0, insuf: 0,
          chg: 0, chg_val: 0, cr: 0, lat: 2};
    if (kind == K_COIN) begin
      if (cr + val > (1 << W) - 1) t.rej = 1;
      else begin cr = cr + val; t.ack = 1; end
    end else if (kind == K_BUY) begin
      if (val > cr) t.insuf = 1;
      else begin
        cr = cr - val;
        t.disp = 1;
`ifdef VEND_AUTO_CHANGE_EN
        t.chg = 1;
        t.chg_val = cr[W-1:0];
        cr = 0;
        t.lat = 3;
`endif
      end
    end else begin
      t.chg = 1;
      t.chg_val = cr[W-1:0];
      cr = 0;
    end
    t.cr = cr[W-1:0];
    return t;
  endfunction

  txn_t tbl[19];

  initial begin
    int n;
    bit got;
    int mcr;
    txn_t t;

    tbl[0]  = '{K_COIN, COIN_10, 1, 0, 0, 0, 0, 0, 10, 2};
    tbl[1]  = '{K_COIN, COIN_5,  1, 0, 0, 0, 0, 0, 15, 2};
    tbl[2]  = '{K_BUY,  20,      0, 0, 0, 1, 0, 0, 15, 2};
    tbl[3]  = '{K_REF,  0,       0, 0, 0, 0, 1, 15, 0, 2};
    tbl[4]  = '{K_REF,  0,       0, 0, 0, 0, 1, 0,  0, 2};
    tbl[5]  = '{K_COIN, COIN_10, 1, 0, 0, 0, 0, 0, 10, 2};
    tbl[6]  = '{K_COIN, COIN_10, 1, 0, 0, 0, 0, 0, 20, 2};
    tbl[7]  = '{K_COIN, COIN_10, 1, 0, 0, 0, 0, 0, 30, 2};
    tbl[8]  = '{K_COIN, COIN_5,  0, 1, 0, 0, 0, 0, 30, 2};
    tbl[9]  = '{K_REF,  0,       0, 0, 0, 0, 1, 30, 0, 2};
    tbl[10] = '{K_COIN, COIN_10, 1, 0, 0, 0, 0, 0, 10, 2};
    tbl[11] = '{K_COIN, COIN_10, 1, 0, 0, 0, 0, 0, 20, 2};
    tbl[12] = '{K_COIN, COIN_5,  1, 0, 0, 0, 0, 0, 25, 2};
    tbl[13] = '{K_COIN, COIN_1,  1, 0, 0, 0, 0, 0, 26, 2};
    tbl[14] = '{K_COIN, COIN_5,  1, 0, 0, 0, 0, 0, 31, 2};
    tbl[15] = '{K_COIN, COIN_1,  0, 1, 0, 0, 0, 0, 31, 2};
    tbl[16] = '{K_REF,  0,       0, 0, 0, 0, 1, 31, 0, 2};
    tbl[17] = '{K_COIN, COIN_10, 1, 0, 0, 0, 0, 0, 10, 2};
    tbl[18] = '{K_COIN, COIN_10, 1, 0, 0, 0, 0, 0, 20, 2};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset credit", credit, 0);
    chk("reset change_val", change_val, 0);
    chk("reset busy", busy, 0);
    chk("reset pulses", any_pulse(), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 19; i++) run_txn($sformatf("tbl%0d", i), tbl[i]);

    // all three requests at once with credit 20: refund, then buy, then coin
    coin_req = 1'b1; coin_val = COIN_5;
    buy_req = 1'b1; price = 5;
    refund_req = 1'b1;
    wait_pulse("prio_ref", n, got);
    chk("prio_ref latency", n, 2);
    chk("prio_ref change_valid", change_valid, 1);
    chk("prio_ref change_val", change_val, 20);
    chk("prio_ref credit", credit, 0);
    chk("prio_ref others", coin_ack | dispense | insufficient, 0);
    @(posedge clk);
    #1 refund_req = 1'b0;
    wait_pulse("prio_buy", n, got);
    chk("prio_buy latency", n, 2);
    chk("prio_buy insufficient", insufficient, 1);
    chk("prio_buy coin_ack", coin_ack, 0);
    chk("prio_buy credit", credit, 0);
    @(posedge clk);
    #1 buy_req = 1'b0;
    wait_pulse("prio_coin", n, got);
    chk("prio_coin latency", n, 2);
    chk("prio_coin coin_ack", coin_ack, 1);
    chk("prio_coin credit", credit, 5);
    @(posedge clk);
    #1 coin_req = 1'b0;

    // reset during EXEC_ADD at credit 10 drops the coin
    run_txn("pre_rst", '{K_COIN, COIN_5, 1, 0, 0, 0, 0, 0, 10, 2});
    coin_req = 1'b1; coin_val = COIN_5;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_exec busy", busy, 1);
    @(posedge clk);
    #1 begin rst = 1'b0; coin_req = 1'b0; end
    @(negedge clk);
    chk("rst_exec credit", credit, 0);
    chk("rst_exec busy_after", busy, 0);
    chk("rst_exec no_ack", any_pulse(), 0);
    @(negedge clk);
    chk("rst_exec no_ack2", any_pulse(), 0);
    @(posedge clk);
    #1;

    // purchases: credit 15, buy 10, then insufficient, then exact fit
    run_txn("buy_c10", '{K_COIN, COIN_10, 1, 0, 0, 0, 0, 0, 10, 2});
    run_txn("buy_c5",  '{K_COIN, COIN_5,  1, 0, 0, 0, 0, 0, 15, 2});
`ifdef VEND_AUTO_CHANGE_EN
    run_txn("buy10",   '{K_BUY,  10,      0, 0, 1, 0, 1, 5, 0, 3});
    run_txn("buy12",   '{K_BUY,  12,      0, 0, 0, 1, 0, 0, 0, 2});
    run_txn("buy_c5b", '{K_COIN, COIN_5,  1, 0, 0, 0, 0, 0, 5, 2});
    run_txn("buy_fit", '{K_BUY,  5,       0, 0, 1, 0, 1, 0, 0, 3});
`else
    run_txn("buy10",   '{K_BUY,  10,      0, 0, 1, 0, 0, 0, 5, 2});
    run_txn("buy12",   '{K_BUY,  12,      0, 0, 0, 1, 0, 0, 5, 2});
    run_txn("buy_fit", '{K_BUY,  5,       0, 0, 1, 0, 0, 0, 0, 2});
`endif

    // random transactions against the model
    mcr = 0;
    for (int i = 0; i < 300; i++) begin
      logic [1:0] k;
      int v;
      k = 2'($urandom_range(0, 2));
      if (k == K_COIN) begin
        case ($urandom_range(0, 3))
          0: v = COIN_1;
          1: v = COIN_5;
          2: v = COIN_10;
          default: v = $urandom_range(0, 31);
        endcase
      end else v = $urandom_range(0, 31);
      t = model(k, v, mcr);
      run_txn($sformatf("rnd%0d", i), t);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // global time limit
  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/vend_credit_ctrl.md
Name: vend_credit_ctrl

Overview:
- Credit controller for the vending machine.
- Time-shares one 5-bit adder/subtractor between three requesters: coin insertion (add), purchase (subtract) and refund.
- Sequences each operation through a small FSM, commits the result to the credit register and returns one-cycle response pulses.
- Sits between the coin/keypad front end and the dispense/change outputs.

Parameters:
- WIDTH, 5, datapath and credit width in bits.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- coin_req  input  1  coin present; level, held until coin_ack or coin_reject
- coin_val  input  WIDTH  coin value, stable while coin_req is high
- buy_req  input  1  purchase request; level, held until dispense or insufficient
- price  input  WIDTH  item price, stable while buy_req is high
- refund_req  input  1  refund request; level, held until change_valid
- coin_ack  output  1  pulse: coin accepted, credit increased
- coin_reject  output  1  pulse: coin refused because credit would overflow
- dispense  output  1  pulse: purchase succeeded
- insufficient  output  1  pulse: purchase refused because credit < price
- change_valid  output  1  pulse: change_val is valid
- change_val  output  WIDTH  returned amount, valid only while change_valid is high
- credit  output  WIDTH  current credit register
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset: state IDLE; credit = 0; change_val = 0; all pulses and busy = 0. An in-flight transaction is dropped with no response.
- FSM states: IDLE, EXEC_ADD, EXEC_SUB, EXEC_REF, RESP.
- IDLE arbitration, fixed priority: refund_req > buy_req > coin_req.
  - The winning operand (coin_val or price) is latched into op_b.
  - Next state is EXEC_REF, EXEC_SUB or EXEC_ADD.
  - Losing requests are not acknowledged and stay pending.
- Shared unit: a = credit, b = op_b, sub = 1 only in EXEC_SUB. Its carry_borrow output means carry-out when adding and borrow (a < b) when subtracting.
- EXEC_ADD:
  - If carry = 0: credit <= sum and coin_ack is set.
  - If carry = 1: credit is unchanged and coin_reject is set.
- EXEC_SUB:
  - If borrow = 0: credit <= difference and dispense is set.
  - If borrow = 1: credit is unchanged and insufficient is set.
- EXEC_REF: change_val <= credit, change_valid is set, credit <= 0. A refund at credit 0 still pulses with change_val = 0.
- All EXEC states go to RESP. Response pulses are registered and high exactly during the RESP cycle. RESP always goes to IDLE.
- Latency:
  - Request sampled in IDLE at cycle 0; EXEC in cycle 1; response pulse in cycle 2; IDLE again in cycle 3.
  - Maximum throughput is one transaction per 3 cycles.
- Handshake: the requester drops its req on the clock edge that ends the pulse cycle. A req still high in cycle 3 is treated as a new request.
- Credit saturation: credit never exceeds 2^WIDTH-1. Exact-fit cases (sum = 31, difference = 0) are legal.
- Only one response pulse is ever high in any cycle.

Optional Feature:
- Macro: VEND_AUTO_CHANGE_EN.
- Defined: a successful EXEC_SUB goes to EXEC_REF instead of RESP.
  - The remaining credit is returned through the normal refund path.
  - dispense and change_valid then pulse together in RESP, with credit cleared.
  - Latency becomes 3 cycles to response.
  - insufficient still skips EXEC_REF.
- Undefined: remaining credit persists for further purchases and is returned only via refund_req.

Decomposition:
- Shared package vend_pkg holds:
  - the state enum (IDLE, EXEC_ADD, EXEC_SUB, EXEC_REF, RESP);
  - WIDTH default;
  - coin denomination constants (COIN_1=1, COIN_5=5, COIN_10=10).
- One sub-module, the existing 5-bit adder/subtractor, instantiated once as the shared unit. The controller contains no other arithmetic.

Test Plan:
- Reset, then coin_val=10 held → coin_ack in cycle 2, credit=10. Second coin 5 → credit=15, busy high in cycles 1–2 of each transaction.
- Credit 15, buy price=5 → dispense pulse, credit=10. Price=12 at credit 10 → insufficient, credit stays 10.
- Credit 30, coin 5 → coin_reject, credit 30. Credit 26, coin 5 → coin_ack, credit 31 (exact fit).
- coin_req, buy_req and refund_req all high in the same IDLE cycle at credit 20 → refund served first (change_val=20, credit=0). Then buy price=5 → insufficient. Then coin 5 → ack, credit=5.
- rst asserted during EXEC_ADD (credit 10, coin 5) → no coin_ack, credit=0 and state IDLE on the next cycle.
- With VEND_AUTO_CHANGE_EN, credit 15, buy price=10 → dispense and change_valid together in cycle 3, change_val=5, credit=0. Without the macro → dispense only, credit=5.
